// File: rtl/clint_pkg.sv
// rtl/clint_pkg.sv - shared constants and decode types for the multi-hart CLINT
package clint_pkg;

    localparam int XLEN      = 32;
    localparam int MAX_HARTS = 16;
    localparam int HART_W    = $clog2(MAX_HARTS);

    // Byte offsets inside the 64 KiB window
    localparam logic [15:0] MSIP_OFS     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFS = 16'h4000;
    localparam logic [15:0] MTIME_LO_OFS = 16'hBFF8;
    localparam logic [15:0] MTIME_HI_OFS = 16'hBFFC;

    typedef enum logic [1:0] {
        OK         = 2'd0,
        BAD_ADDR   = 2'd1,
        MISALIGNED = 2'd2
    } clint_err_e;

endpackage

// File: rtl/clint_timebase.sv
// rtl/clint_timebase.sv - prescaler and shared 64-bit mtime counter with word writes
module clint_timebase #(
    parameter int TICK_DIV = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_lo,
    input  logic        i_wr_hi,
    input  logic [31:0] i_wrdata,
    output logic [63:0] o_mtime
);

    localparam logic [15:0] W_LAST = 16'(TICK_DIV - 1);

    logic [15:0] r_cnt;
    logic [63:0] r_mtime;
    logic        w_tick;
    logic [63:0] w_inc;
    logic [63:0] w_next;

    assign w_tick  = (r_cnt == W_LAST);
    assign w_inc   = w_tick ? (r_mtime + 64'd1) : r_mtime;
    assign o_mtime = r_mtime;

    // Prescaler: free-running 0..TICK_DIV-1, never disturbed by bus writes
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // A written word wins; the other word keeps its ticked value, carry included
    always_comb begin
        w_next = w_inc;
        if (i_wr_lo) begin
            w_next[31:0] = i_wrdata;
        end
        if (i_wr_hi) begin
            w_next[63:32] = i_wrdata;
        end
    end

    // mtime register, wraps silently at 2^64
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mtime <= '0;
        end else begin
            r_mtime <= w_next;
        end
    end

endmodule

// File: rtl/clint_mh.sv
// rtl/clint_mh.sv - multi-hart core-local interruptor with registered bus slave
module clint_mh
    import clint_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int          N_HARTS   = 4,
    parameter int          TICK_DIV  = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req,
    input  logic               i_wen,
    input  logic [XLEN-1:0]    i_addr,
    input  logic [XLEN-1:0]    i_wrdata,
    output logic               o_ack,
    output logic               o_err,
    output logic [XLEN-1:0]    o_rddata,
    output logic [N_HARTS-1:0] o_msip,
    output logic [N_HARTS-1:0] o_mtip
);

    localparam logic [13:0] N_H14 = 14'(N_HARTS);

    logic [N_HARTS-1:0] r_msip;
    logic [63:0]        r_cmp [N_HARTS];
    logic [N_HARTS-1:0] r_mtip;
    logic               r_ack;
    logic               r_err;
    logic [XLEN-1:0]    r_rddata;

    logic [13:0]        w_ofs;
    logic [13:0]        w_msip_rel;
    logic [13:0]        w_cmp_rel;
    logic               w_in_window;
    clint_err_e         w_err_kind;
    logic               w_sel_msip;
    logic               w_sel_cmp;
    logic               w_sel_tlo;
    logic               w_sel_thi;
    logic               w_cmp_hi;
    logic [HART_W-1:0]  w_hart;
    logic               w_wr;
    logic [XLEN-1:0]    w_rd;
    logic [63:0]        w_mtime;

    // Word offset inside the window; byte lanes are checked separately
    assign w_ofs       = i_addr[15:2];
    assign w_msip_rel  = w_ofs - MSIP_OFS[15:2];
    assign w_cmp_rel   = w_ofs - MTIMECMP_OFS[15:2];
    assign w_in_window = (i_addr[31:16] == BASE_ADDR[31:16]);

    // Address decode: region select, hart index and error classification
    always_comb begin
        w_err_kind = BAD_ADDR;
        w_sel_msip = 1'b0;
        w_sel_cmp  = 1'b0;
        w_sel_tlo  = 1'b0;
        w_sel_thi  = 1'b0;
        w_cmp_hi   = 1'b0;
        w_hart     = '0;
        if (i_addr[1:0] != 2'b00) begin
            w_err_kind = MISALIGNED;
        end else if (w_in_window) begin
            if (w_ofs < MTIMECMP_OFS[15:2]) begin
                if (w_msip_rel < N_H14) begin
                    w_err_kind = OK;
                    w_sel_msip = 1'b1;
                    w_hart     = w_msip_rel[HART_W-1:0];
                end
            end else if (w_ofs < MTIME_LO_OFS[15:2]) begin
                if ({1'b0, w_cmp_rel[13:1]} < N_H14) begin
                    w_err_kind = OK;
                    w_sel_cmp  = 1'b1;
                    w_cmp_hi   = w_cmp_rel[0];
                    w_hart     = w_cmp_rel[HART_W:1];
                end
            end else if (w_ofs == MTIME_LO_OFS[15:2]) begin
                w_err_kind = OK;
                w_sel_tlo  = 1'b1;
            end else if (w_ofs == MTIME_HI_OFS[15:2]) begin
                w_err_kind = OK;
                w_sel_thi  = 1'b1;
            end
        end
    end

    assign w_wr = i_req & i_wen & (w_err_kind == OK);

    clint_timebase #(
        .TICK_DIV (TICK_DIV)
    ) u_timebase (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_wr_lo  (w_wr & w_sel_tlo),
        .i_wr_hi  (w_wr & w_sel_thi),
        .i_wrdata (i_wrdata),
        .o_mtime  (w_mtime)
    );

    // Read mux over current (pre-write) register values
    always_comb begin
        w_rd = '0;
        for (int h = 0; h < N_HARTS; h++) begin
            if (w_hart == HART_W'(h)) begin
                if (w_sel_msip) begin
                    w_rd = {{(XLEN-1){1'b0}}, r_msip[h]};
                end else if (w_sel_cmp) begin
                    w_rd = w_cmp_hi ? r_cmp[h][63:32] : r_cmp[h][31:0];
                end
            end
        end
        if (w_sel_tlo) begin
            w_rd = w_mtime[31:0];
        end else if (w_sel_thi) begin
            w_rd = w_mtime[63:32];
        end
    end

    // Per-hart msip bit and mtimecmp words, updated by error-free writes only
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_msip <= '0;
            for (int h = 0; h < N_HARTS; h++) begin
                r_cmp[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
            end
        end else if (w_wr) begin
            for (int h = 0; h < N_HARTS; h++) begin
                if (w_hart == HART_W'(h)) begin
                    if (w_sel_msip) begin
                        r_msip[h] <= i_wrdata[0];
                    end
                    if (w_sel_cmp && w_cmp_hi) begin
                        r_cmp[h][63:32] <= i_wrdata;
                    end
                    if (w_sel_cmp && !w_cmp_hi) begin
                        r_cmp[h][31:0] <= i_wrdata;
                    end
                end
            end
        end
    end

    // Timer interrupt: registered unsigned compare on current register values
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mtip <= '0;
        end else begin
            for (int h = 0; h < N_HARTS; h++) begin
                r_mtip[h] <= (w_mtime >= r_cmp[h]);
            end
        end
    end

    // Bus response: one ack per request, data only for good reads
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_rddata <= '0;
        end else begin
            r_ack    <= i_req;
            r_err    <= i_req & (w_err_kind != OK);
            r_rddata <= (i_req && !i_wen && (w_err_kind == OK)) ? w_rd : '0;
        end
    end

    assign o_ack    = r_ack;
    assign o_err    = r_err;
    assign o_rddata = r_rddata;
    assign o_msip   = r_msip;
    assign o_mtip   = r_mtip;

endmodule
